alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width per pass.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-006 cmd_op  input  4  ARM data-processing opcode (AND=0000 … MVN=1111).
REQ-007 cmd_s  input  1  update NZCV flags on completion.
REQ-008 cmd_long  input  1  64-bit two-pass operation.
REQ-009 cmd_a_lo, cmd_b_lo  input  WIDTH each  low operands.
REQ-010 cmd_a_hi, cmd_b_hi  input  WIDTH each  high operands; used only when long.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  consumer accepts result.
REQ-013 rsp_lo, rsp_hi  output  WIDTH each  result halves.
REQ-014 rsp_wb  output  1  writeback enable.
REQ-015 flags_nzcv  output  4  architectural flags {N,Z,C,V}.
REQ-016 busy  output  1  high in any state except IDLE.

Function
REQ-017 Sequencer SHALL contain one internal 32-bit ALU implementing the team's ARM opcode encoding, time-shared across passes.
REQ-018 States SHALL be IDLE, PASS_LO, PASS_HI, RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE; cmd_valid&cmd_ready latches all cmd_* fields; transition to PASS_LO.
REQ-020 PASS_LO: ALU operands are the latched lo operands; carry_in = flags C for ADC/SBC/RSC, else don't-care; on the edge, capture result into rsp_lo and ALU carry into an internal carry register.
REQ-021 Long path: if cmd_long and op is ADD or ADC, PASS_HI uses ADC; if SUB or SBC, PASS_HI uses SBC; carry_in = internal carry register; capture into rsp_hi; then RESP.
REQ-022 Otherwise PASS_LO goes directly to RESP and rsp_hi SHALL be 0 (cmd_long with any other op executes as single pass).
REQ-023 Latency: rsp_valid rises 2 cycles after the accept cycle (single pass), 3 cycles (long).
REQ-024 RESP: rsp_valid=1; rsp_lo/rsp_hi/rsp_wb stable until rsp_ready=1, then IDLE next cycle. No new command is accepted in that same cycle.
REQ-025 rsp_wb SHALL be 0 for TST, TEQ, CMP, CMN; 1 otherwise.
REQ-026 Flags SHALL update on the edge entering RESP, only if cmd_s=1. N and Z are from the final result; for long operations Z=(rsp_hi==0 && rsp_lo==0) and N=rsp_hi[31].
REQ-027 C and V SHALL update only for arithmetic ops (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN), taken from the final pass. Logical ops SHALL preserve C and V.
REQ-028 Throughput SHALL be at most 1 command per 3 cycles (single) or 4 cycles (long); rsp_ready held low stalls indefinitely without loss.

Reset
REQ-029 rst=1 SHALL force IDLE; rsp_valid=0, rsp_lo=rsp_hi=0, rsp_wb=0, flags_nzcv=0000, internal carry=0, busy=0.
REQ-030 rst SHALL abort any in-flight operation, including one in RESP; no flags update and no response appear from it.
REQ-031 rst SHALL dominate cmd_valid in the same cycle.

Verification
REQ-032 ADD, S=1, a=0x7FFFFFFF, b=1 -> rsp_valid 2 cycles after accept, rsp_lo=0x80000000, wb=1, NZCV=1001.
REQ-033 Long SUB, S=1, a=0x00000001_00000000, b=0x00000000_00000001 -> 3-cycle latency, {hi,lo}=0x00000000_FFFFFFFF, NZCV=0010.
REQ-034 Set C=1, then CMP a=5, b=5 with S=1 -> wb=0, NZCV=0110. Then AND S=1, a=0xF0, b=0x0F -> result 0, NZCV=0110 (C,V preserved).
REQ-035 ADC with flags C=1, a=1, b=1, S=0 -> rsp_lo=3; flags unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp outputs stable, cmd_ready=0 throughout; assert rsp_ready -> IDLE next cycle.
REQ-037 Assert rst during PASS_HI of a long ADD with S=1 -> next cycle IDLE, flags=0000, rsp_valid never asserted for that command.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-pass ARM data-processing sequencer: one time-shared ALU runs a single
// pass, or two chained passes for 64-bit add/subtract, with a ready/valid response.
module alu_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic             cmd_s,
    input  logic             cmd_long,
    input  logic [WIDTH-1:0] cmd_a_lo,
    input  logic [WIDTH-1:0] cmd_b_lo,
    input  logic [WIDTH-1:0] cmd_a_hi,
    input  logic [WIDTH-1:0] cmd_b_hi,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_lo,
    output logic [WIDTH-1:0] rsp_hi,
    output logic             rsp_wb,
    output logic [3:0]       flags_nzcv,
    output logic             busy
);

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND = 4'h0;
    localparam logic [OP_W-1:0] OP_EOR = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_RSB = 4'h3;
    localparam logic [OP_W-1:0] OP_ADD = 4'h4;
    localparam logic [OP_W-1:0] OP_ADC = 4'h5;
    localparam logic [OP_W-1:0] OP_SBC = 4'h6;
    localparam logic [OP_W-1:0] OP_RSC = 4'h7;
    localparam logic [OP_W-1:0] OP_TST = 4'h8;
    localparam logic [OP_W-1:0] OP_TEQ = 4'h9;
    localparam logic [OP_W-1:0] OP_CMP = 4'hA;
    localparam logic [OP_W-1:0] OP_CMN = 4'hB;
    localparam logic [OP_W-1:0] OP_ORR = 4'hC;
    localparam logic [OP_W-1:0] OP_MOV = 4'hD;
    localparam logic [OP_W-1:0] OP_BIC = 4'hE;
    localparam logic [OP_W-1:0] OP_MVN = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PASS_LO = 2'd1,
        PASS_HI = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state;
    logic [OP_W-1:0]   op_q;
    logic              s_q;
    logic              long_q;
    logic [WIDTH-1:0]  a_lo_q, b_lo_q, a_hi_q, b_hi_q;
    logic              carry_q;

    logic [OP_W-1:0]   alu_op;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_x, alu_y, alu_res;
    logic              alu_cin, alu_cin_eff, alu_arith, alu_c, alu_v;
    logic [WIDTH:0]    alu_sum;
    logic              long_path_c;
    logic              wb_c;
    logic              res_zero_c;
    logic [3:0]        flags_upd_c;

    // Only add/subtract families chain into a second pass; other long commands run single.
    assign long_path_c = long_q && (op_q == OP_ADD || op_q == OP_ADC ||
                                    op_q == OP_SUB || op_q == OP_SBC);
    assign wb_c = !(op_q == OP_TST || op_q == OP_TEQ || op_q == OP_CMP || op_q == OP_CMN);

    // Operand selection: the high pass always runs as ADC or SBC on the saved carry.
    always_comb begin
        alu_op  = op_q;
        alu_a   = a_lo_q;
        alu_b   = b_lo_q;
        alu_cin = flags_nzcv[1];
        if (state == PASS_HI) begin
            alu_op  = (op_q == OP_ADD || op_q == OP_ADC) ? OP_ADC : OP_SBC;
            alu_a   = a_hi_q;
            alu_b   = b_hi_q;
            alu_cin = carry_q;
        end
    end

    // Shared ALU: subtraction is x + ~y + cin, so C means "no borrow".
    always_comb begin
        alu_x       = alu_a;
        alu_y       = alu_b;
        alu_cin_eff = 1'b0;
        alu_arith   = 1'b0;
        case (alu_op)
            OP_SUB, OP_CMP: begin alu_y = ~alu_b; alu_cin_eff = 1'b1; alu_arith = 1'b1; end
            OP_RSB: begin alu_x = alu_b; alu_y = ~alu_a; alu_cin_eff = 1'b1; alu_arith = 1'b1; end
            OP_ADD, OP_CMN: alu_arith = 1'b1;
            OP_ADC: begin alu_cin_eff = alu_cin; alu_arith = 1'b1; end
            OP_SBC: begin alu_y = ~alu_b; alu_cin_eff = alu_cin; alu_arith = 1'b1; end
            OP_RSC: begin alu_x = alu_b; alu_y = ~alu_a; alu_cin_eff = alu_cin; alu_arith = 1'b1; end
            default: ;
        endcase
        alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + (WIDTH+1)'(alu_cin_eff);
        case (alu_op)
            OP_AND, OP_TST: alu_res = alu_a & alu_b;
            OP_EOR, OP_TEQ: alu_res = alu_a ^ alu_b;
            OP_ORR:         alu_res = alu_a | alu_b;
            OP_MOV:         alu_res = alu_b;
            OP_BIC:         alu_res = alu_a & ~alu_b;
            OP_MVN:         alu_res = ~alu_b;
            default:        alu_res = alu_sum[WIDTH-1:0];
        endcase
        alu_c = alu_sum[WIDTH];
        alu_v = (alu_x[WIDTH-1] == alu_y[WIDTH-1]) && (alu_sum[WIDTH-1] != alu_x[WIDTH-1]);
    end

    // Flags for the final pass; Z spans both halves when the high pass is running.
    always_comb begin
        res_zero_c = (alu_res == '0);
        if (state == PASS_HI) begin
            res_zero_c = (alu_res == '0) && (rsp_lo == '0);
        end
        flags_upd_c = {alu_res[WIDTH-1], res_zero_c,
                       alu_arith ? alu_c : flags_nzcv[1],
                       alu_arith ? alu_v : flags_nzcv[0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_lo     <= '0;
            rsp_hi     <= '0;
            rsp_wb     <= 1'b0;
            flags_nzcv <= 4'b0000;
            carry_q    <= 1'b0;
            op_q       <= '0;
            s_q        <= 1'b0;
            long_q     <= 1'b0;
            a_lo_q     <= '0;
            b_lo_q     <= '0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        s_q       <= cmd_s;
                        long_q    <= cmd_long;
                        a_lo_q    <= cmd_a_lo;
                        b_lo_q    <= cmd_b_lo;
                        a_hi_q    <= cmd_a_hi;
                        b_hi_q    <= cmd_b_hi;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= PASS_LO;
                    end
                end
                PASS_LO: begin
                    rsp_lo  <= alu_res;
                    rsp_hi  <= '0;
                    carry_q <= alu_c;
                    if (long_path_c) begin
                        state <= PASS_HI;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_wb    <= wb_c;
                        if (s_q) flags_nzcv <= flags_upd_c;
                        state     <= RESP;
                    end
                end
                PASS_HI: begin
                    rsp_hi    <= alu_res;
                    rsp_valid <= 1'b1;
                    rsp_wb    <= wb_c;
                    if (s_q) flags_nzcv <= flags_upd_c;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, reset corner cases, and
// randomized commands checked against a wide-arithmetic reference model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic        cmd_s = 1'b0;
    logic        cmd_long = 1'b0;
    logic [31:0] cmd_a_lo = '0, cmd_b_lo = '0, cmd_a_hi = '0, cmd_b_hi = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_lo, rsp_hi;
    logic        rsp_wb;
    logic [3:0]  flags_nzcv;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] model_flags = 4'b0000;

    alu_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_s(cmd_s), .cmd_long(cmd_long),
        .cmd_a_lo(cmd_a_lo), .cmd_b_lo(cmd_b_lo),
        .cmd_a_hi(cmd_a_hi), .cmd_b_hi(cmd_b_hi),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_wb(rsp_wb),
        .flags_nzcv(flags_nzcv), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  op;
        bit          s;
        bit          lng;
        logic [63:0] a;
        logic [63:0] b;
        int          stall;
        logic [31:0] lo;
        logic [31:0] hi;
        bit          wb;
        logic [3:0]  nzcv;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // x op y over n bits with true (wide) arithmetic; sub computes x - y - borrow.
    task automatic ref_arith(input logic [63:0] x, input logic [63:0] y, input bit sub,
                             input bit cin, input int n,
                             output logic [63:0] r, output bit c, output bit v);
        logic signed [67:0] lim, ux, uy, sx, sy, u, sv, ci;
        lim = 68'sd1 <<< n;
        ux  = $signed({4'b0000, x});
        uy  = $signed({4'b0000, y});
        sx  = x[n-1] ? ux - lim : ux;
        sy  = y[n-1] ? uy - lim : uy;
        ci  = cin ? 68'sd1 : 68'sd0;
        if (!sub) begin
            u  = ux + uy + ci;
            sv = sx + sy + ci;
            c  = (u >= lim);
        end else begin
            u  = ux - uy - (68'sd1 - ci);
            sv = sx - sy - (68'sd1 - ci);
            c  = (u >= 68'sd0);
        end
        v = (sv >= (lim >>> 1)) || (sv < -(lim >>> 1));
        r = (n == 32) ? {32'h0, u[31:0]} : u[63:0];
    endtask

    task automatic ref_model(input logic [3:0] op, input bit s, input bit lng,
                             input logic [63:0] a, input logic [63:0] b, input logic [3:0] fin,
                             output logic [31:0] lo, output logic [31:0] hi, output bit wb,
                             output logic [3:0] fout, output int lat);
        bit chained, arith, c, v, cf;
        int n;
        logic [63:0] am, bm, r, msk;
        chained = lng && (op inside {4'h2, 4'h4, 4'h5, 4'h6});
        arith   = op inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB};
        n       = chained ? 64 : 32;
        msk     = chained ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        am      = a & msk;
        bm      = b & msk;
        cf      = fin[1];
        c = 1'b0; v = 1'b0; r = '0;
        case (op)
            4'h0, 4'h8: r = am & bm;
            4'h1, 4'h9: r = am ^ bm;
            4'hC:       r = am | bm;
            4'hD:       r = bm;
            4'hE:       r = am & ~bm;
            4'hF:       r = ~bm;
            4'h2, 4'hA: ref_arith(am, bm, 1'b1, 1'b1, n, r, c, v);
            4'h3:       ref_arith(bm, am, 1'b1, 1'b1, n, r, c, v);
            4'h4, 4'hB: ref_arith(am, bm, 1'b0, 1'b0, n, r, c, v);
            4'h5:       ref_arith(am, bm, 1'b0, cf, n, r, c, v);
            4'h6:       ref_arith(am, bm, 1'b1, cf, n, r, c, v);
            default:    ref_arith(bm, am, 1'b1, cf, n, r, c, v);
        endcase
        r    = r & msk;
        lo   = r[31:0];
        hi   = r[63:32];
        wb   = !(op inside {4'h8, 4'h9, 4'hA, 4'hB});
        lat  = chained ? 3 : 2;
        fout = fin;
        if (s) begin
            fout[3] = r[n-1];
            fout[2] = (r == 64'h0);
            if (arith) begin
                fout[1] = c;
                fout[0] = v;
            end
        end
    endtask

    // Full transaction: offer, measure latency, check result, stall, then retire.
    task automatic run_cmd(input string tag, input logic [3:0] op, input bit s, input bit lng,
                           input logic [63:0] a, input logic [63:0] b, input int stall,
                           input logic [31:0] e_lo, input logic [31:0] e_hi, input bit e_wb,
                           input logic [3:0] e_nzcv, input int e_lat);
        int k;
        int lat;
        k = 0;
        while (!cmd_ready && k < 10) begin @(posedge clk); #1; k++; end
        check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_s = s; cmd_long = lng;
        cmd_a_lo = a[31:0]; cmd_a_hi = a[63:32]; cmd_b_lo = b[31:0]; cmd_b_hi = b[63:32];
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 4'($urandom_range(15, 0)); cmd_s = 1'($urandom_range(1, 0));
        cmd_a_lo = $urandom; cmd_a_hi = $urandom; cmd_b_lo = $urandom; cmd_b_hi = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 12) begin @(posedge clk); #1; lat++; end
        check({tag, " latency"}, 64'(lat), 64'(e_lat));
        check({tag, " rsp_lo"}, 64'(rsp_lo), 64'(e_lo));
        check({tag, " rsp_hi"}, 64'(rsp_hi), 64'(e_hi));
        check({tag, " rsp_wb"}, 64'(rsp_wb), 64'(e_wb));
        check({tag, " nzcv"}, 64'(flags_nzcv), 64'(e_nzcv));
        check({tag, " busy"}, 64'(busy), 64'd1);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, " stall rsp_valid"}, 64'(rsp_valid), 64'd1);
            check({tag, " stall rsp_lo"}, 64'(rsp_lo), 64'(e_lo));
            check({tag, " stall rsp_hi"}, 64'(rsp_hi), 64'(e_hi));
            check({tag, " stall cmd_ready"}, 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, " retire rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, " retire cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, " retire busy"}, 64'(busy), 64'd0);
    endtask

    vec_t vecs[12];

    initial begin
        logic [31:0] e_lo, e_hi;
        logic [3:0]  e_f;
        logic [63:0] ra, rb;
        logic [3:0]  rop;
        bit          e_wb, rs, rl;
        int          e_lat;

        vecs[0]  = '{4'h4, 1, 0, 64'h7FFF_FFFF, 64'h1, 5, 32'h8000_0000, 32'h0, 1, 4'b1001, 2};
        vecs[1]  = '{4'h2, 1, 1, 64'h1_0000_0000, 64'h1, 0, 32'hFFFF_FFFF, 32'h0, 1, 4'b0010, 3};
        vecs[2]  = '{4'hA, 1, 0, 64'h5, 64'h5, 1, 32'h0, 32'h0, 0, 4'b0110, 2};
        vecs[3]  = '{4'h0, 1, 0, 64'hF0, 64'h0F, 0, 32'h0, 32'h0, 1, 4'b0110, 2};
        vecs[4]  = '{4'h5, 0, 0, 64'h1, 64'h1, 0, 32'h3, 32'h0, 1, 4'b0110, 2};
        vecs[5]  = '{4'h4, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2, 32'h0, 32'h0, 1, 4'b0110, 3};
        vecs[6]  = '{4'h0, 1, 1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0,
                     32'h8000_0000, 32'h0, 1, 4'b1010, 2};
        vecs[7]  = '{4'hF, 1, 0, 64'h1234, 64'h0, 0, 32'hFFFF_FFFF, 32'h0, 1, 4'b1010, 2};
        vecs[8]  = '{4'h9, 1, 0, 64'h5, 64'h5, 0, 32'h0, 32'h0, 0, 4'b0110, 2};
        vecs[9]  = '{4'h3, 1, 0, 64'h1, 64'h0, 0, 32'hFFFF_FFFF, 32'h0, 1, 4'b1000, 2};
        vecs[10] = '{4'h6, 1, 0, 64'h5, 64'h3, 0, 32'h1, 32'h0, 1, 4'b0010, 2};
        vecs[11] = '{4'h6, 1, 1, 64'h2_0000_0000, 64'h1_0000_0001, 0,
                     32'hFFFF_FFFF, 32'h0, 1, 4'b0010, 3};

        repeat (3) @(posedge clk);
        #1;
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_lo", 64'(rsp_lo), 64'd0);
        check("reset rsp_hi", 64'(rsp_hi), 64'd0);
        check("reset rsp_wb", 64'(rsp_wb), 64'd0);
        check("reset nzcv", 64'(flags_nzcv), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset cmd_ready", 64'(cmd_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].s, vecs[i].lng, vecs[i].a,
                    vecs[i].b, vecs[i].stall, vecs[i].lo, vecs[i].hi, vecs[i].wb,
                    vecs[i].nzcv, vecs[i].lat);
            model_flags = vecs[i].nzcv;
        end

        // Reset during the high pass of a long ADD aborts it with no response.
        cmd_valid = 1'b1; cmd_op = 4'h4; cmd_s = 1'b1; cmd_long = 1'b1;
        cmd_a_lo = 32'hFFFF_FFFF; cmd_b_lo = 32'h1; cmd_a_hi = 32'h7FFF_FFFF; cmd_b_hi = 32'h0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("abort pass_hi busy", 64'(busy), 64'd1);
        check("abort pass_hi rsp_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort cmd_ready", 64'(cmd_ready), 64'd1);
        check("abort nzcv", 64'(flags_nzcv), 64'd0);
        check("abort rsp_hi", 64'(rsp_hi), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort no rsp_valid", 64'(rsp_valid), 64'd0);
        end
        model_flags = 4'b0000;

        // Reset while holding a response in RESP drops it.
        cmd_valid = 1'b1; cmd_op = 4'h2; cmd_s = 1'b1; cmd_long = 1'b0;
        cmd_a_lo = 32'h1; cmd_b_lo = 32'h2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("resp abort rsp_valid pre", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("resp abort rsp_valid", 64'(rsp_valid), 64'd0);
        check("resp abort rsp_lo", 64'(rsp_lo), 64'd0);
        check("resp abort nzcv", 64'(flags_nzcv), 64'd0);

        // Reset wins over a simultaneous command offer.
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 4'h4;
        @(posedge clk); #1;
        rst = 1'b0; cmd_valid = 1'b0;
        check("rst vs cmd busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("rst vs cmd busy later", 64'(busy), 64'd0);
        check("rst vs cmd rsp_valid", 64'(rsp_valid), 64'd0);

        for (int t = 0; t < 300; t++) begin
            rop = 4'($urandom_range(15, 0));
            rs  = 1'($urandom_range(1, 0));
            rl  = 1'($urandom_range(1, 0));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if ($urandom_range(3, 0) == 0) rb = ra;
            ref_model(rop, rs, rl, ra, rb, model_flags, e_lo, e_hi, e_wb, e_f, e_lat);
            run_cmd($sformatf("rnd%0d op%0h", t, rop), rop, rs, rl, ra, rb,
                    int'($urandom_range(2, 0)), e_lo, e_hi, e_wb, e_f, e_lat);
            model_flags = e_f;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
